// File: rtl/wbarb_pkg.sv
// Shared types, constants and the round-robin pick function for the wbarb Wishbone arbiter.
// Latency: n/a (types, constants and a combinational function only).
// Backpressure: n/a.
package wbarb_pkg;

    // Upper bound on the master count; the picker always works on this many request bits.
    localparam int NM_MAX = 8;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_GRANTED = 1'b1
    } state_t;

    // Wishbone cycle type identifiers
    localparam logic [2:0] CTI_CLASSIC   = 3'b000;
    localparam logic [2:0] CTI_INC_BURST = 3'b010;
    localparam logic [2:0] CTI_END_BURST = 3'b111;

    typedef struct packed {
        logic       vld;
        logic [2:0] idx;
    } pick_t;

    // First set bit of req scanning upward from last+1, wrapping modulo nm.
    // Bits at or above nm are never selected.
    function automatic pick_t rr_pick(input logic [NM_MAX-1:0] req,
                                      input logic [2:0]        last,
                                      input int                nm);
        pick_t      p;
        int         pos;
        logic [2:0] pos3;
        p = '0;
        for (int k = 1; k <= NM_MAX; k++) begin
            if (k <= nm && !p.vld) begin
                pos  = (int'(last) + k) % nm;
                pos3 = 3'(pos);
                if (req[pos3]) begin
                    p.vld = 1'b1;
                    p.idx = pos3;
                end
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/wbarb_if.sv
// Bundle of all per-master and shared-slave Wishbone signals around the wbarb arbiter.
// Latency: n/a (wires only).
// Backpressure: n/a; the ack/err lines inside carry the Wishbone stall semantics.
// Ports: per-master buses are packed, master i in slice i. Modport 'slave' is the
// arbiter's view (it is the slave the masters talk to and drives the shared bus);
// modport 'master' is the view of the surrounding agents (masters plus the target).
interface wbarb_if #(
    parameter int NM = 4
);
    logic [NM*32-1:0] m_adr_i;
    logic [NM*32-1:0] m_dat_i;
    logic [NM*4-1:0]  m_sel_i;
    logic [NM*3-1:0]  m_cti_i;
    logic [NM-1:0]    m_we_i;
    logic [NM-1:0]    m_cyc_i;
    logic [NM-1:0]    m_stb_i;
    logic [31:0]      m_dat_o;
    logic [NM-1:0]    m_ack_o;
    logic [NM-1:0]    m_err_o;

    logic [31:0]      s_adr_o;
    logic [31:0]      s_dat_o;
    logic [3:0]       s_sel_o;
    logic [2:0]       s_cti_o;
    logic             s_we_o;
    logic             s_cyc_o;
    logic             s_stb_o;
    logic [31:0]      s_dat_i;
    logic             s_ack_i;

    logic [NM-1:0]    gnt_o;

    modport slave (
        input  m_adr_i, m_dat_i, m_sel_i, m_cti_i, m_we_i, m_cyc_i, m_stb_i,
        input  s_dat_i, s_ack_i,
        output m_dat_o, m_ack_o, m_err_o,
        output s_adr_o, s_dat_o, s_sel_o, s_cti_o, s_we_o, s_cyc_o, s_stb_o,
        output gnt_o
    );

    modport master (
        output m_adr_i, m_dat_i, m_sel_i, m_cti_i, m_we_i, m_cyc_i, m_stb_i,
        output s_dat_i, s_ack_i,
        input  m_dat_o, m_ack_o, m_err_o,
        input  s_adr_o, s_dat_o, s_sel_o, s_cti_o, s_we_o, s_cyc_o, s_stb_o,
        input  gnt_o
    );

endinterface

// File: rtl/wbarb_rr.sv
// Combinational round-robin picker: first requester after 'last', wrapping modulo NM.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; requests are sampled as presented, nothing is latched.
// Ports: req (one bit per master), last (previous winner), vld/idx (winner found / index).
module wbarb_rr
    import wbarb_pkg::*;
#(
    parameter int NM = 4
) (
    input  logic [NM-1:0] req,
    input  logic [2:0]    last,
    output logic          vld,
    output logic [2:0]    idx
);

    logic [NM_MAX-1:0] req_ext;
    pick_t             pick;

    always_comb begin
        req_ext         = '0;
        req_ext[NM-1:0] = req;
        pick            = rr_pick(req_ext, last, NM);
    end

    assign vld = pick.vld;
    assign idx = pick.idx;

endmodule

// File: rtl/wbarb.sv
// Round-robin Wishbone arbiter: NM masters share one slave port, grant held for the whole cyc.
// Latency: cyc seen at edge n -> grant at n+1; one dead IDLE cycle between owners; data path combinational.
// Backpressure: losers see no ack and must hold cyc/stb; owner stalls on the slave ack; never preempts.
// Ports: sys_clk, sys_rst_n (async active-low), bus (wbarb_if.slave: per-master m_*, shared s_*, gnt_o).
// Build option WBARB_TIMEOUT_EN: watchdog errors a cycle after TIMEOUT strobed cycles without ack.
module wbarb
    import wbarb_pkg::*;
#(
    parameter int NM      = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic    sys_clk,
    input  logic    sys_rst_n,
    wbarb_if.slave  bus
);

    state_t     state, state_nx;
    logic [2:0] own, own_nx;
    logic [2:0] last, last_nx;
    logic       pick_vld;
    logic [2:0] pick_idx;
    logic       granted;
    logic       owner_cyc;
    logic       owner_stb;
    logic       wd_fire;
    logic [2:0] mux_idx;

    wbarb_rr #(.NM(NM)) u_rr (
        .req  (bus.m_cyc_i),
        .last (last),
        .vld  (pick_vld),
        .idx  (pick_idx)
    );

    assign granted = (state == ST_GRANTED);

    always_comb begin
        owner_cyc = 1'b0;
        owner_stb = 1'b0;
        for (int i = 0; i < NM; i++) begin
            if (own == 3'(i)) begin
                owner_cyc = bus.m_cyc_i[i];
                owner_stb = bus.m_stb_i[i];
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state <= ST_IDLE;
            own   <= '0;
            last  <= 3'(NM - 1);   // master 0 wins first after reset
        end else begin
            state <= state_nx;
            own   <= own_nx;
            last  <= last_nx;
        end
    end

    always_comb begin
        state_nx = state;
        own_nx   = own;
        last_nx  = last;
        case (state)
            ST_IDLE: begin
                if (pick_vld) begin
                    state_nx = ST_GRANTED;
                    own_nx   = pick_idx;
                    last_nx  = pick_idx;
                end
            end
            ST_GRANTED: begin
                // Release only on the owner's cyc low; a hand-over always passes through IDLE.
                if (!owner_cyc) begin
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

`ifdef WBARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] wd_cnt;

    assign wd_fire = granted && (wd_cnt == CW'(TIMEOUT));

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wd_cnt <= '0;
        end else if (!granted || state_nx != ST_GRANTED || bus.s_ack_i || wd_fire) begin
            wd_cnt <= '0;
        end else if (owner_stb) begin
            wd_cnt <= wd_cnt + CW'(1);
        end
    end
`else
    logic unused_cfg;
    assign wd_fire    = 1'b0;
    assign unused_cfg = ^(32'(TIMEOUT));
`endif

    // In IDLE the data path shows master 0; the slave ignores it since cyc/stb are low.
    assign mux_idx = granted ? own : 3'd0;

    always_comb begin
        bus.s_adr_o = '0;
        bus.s_dat_o = '0;
        bus.s_sel_o = '0;
        bus.s_cti_o = '0;
        bus.s_we_o  = 1'b0;
        for (int i = 0; i < NM; i++) begin
            if (mux_idx == 3'(i)) begin
                bus.s_adr_o = bus.m_adr_i[i*32 +: 32];
                bus.s_dat_o = bus.m_dat_i[i*32 +: 32];
                bus.s_sel_o = bus.m_sel_i[i*4 +: 4];
                bus.s_cti_o = bus.m_cti_i[i*3 +: 3];
                bus.s_we_o  = bus.m_we_i[i];
            end
        end
    end

    // Strobe is withdrawn in the watchdog cycle so the slave cannot complete the errored access.
    assign bus.s_cyc_o = granted && owner_cyc;
    assign bus.s_stb_o = granted && owner_stb && !wd_fire;
    assign bus.m_dat_o = bus.s_dat_i;

    always_comb begin
        bus.m_ack_o = '0;
        bus.m_err_o = '0;
        bus.gnt_o   = '0;
        for (int i = 0; i < NM; i++) begin
            if (granted && own == 3'(i)) begin
                bus.gnt_o[i]   = 1'b1;
                bus.m_ack_o[i] = bus.s_ack_i;
                bus.m_err_o[i] = wd_fire;
            end
        end
    end

endmodule

// File: tb/tb_wbarb.sv
// Directed bench for wbarb (NM=4, TIMEOUT=16): reset, single read, tie-break, rotation,
// burst hold, watchdog (when WBARB_TIMEOUT_EN is defined) and asynchronous reset mid-cycle.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_wbarb;
    import wbarb_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    wbarb_if #(.NM(4)) bus ();

    wbarb #(.NM(4), .TIMEOUT(16)) dut (
        .sys_clk   (clk),
        .sys_rst_n (rst_n),
        .bus       (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_bus();
        bus.m_adr_i = '0;
        bus.m_dat_i = '0;
        bus.m_sel_i = '0;
        bus.m_cti_i = '0;
        bus.m_we_i  = '0;
        bus.m_cyc_i = '0;
        bus.m_stb_i = '0;
        bus.s_dat_i = '0;
        bus.s_ack_i = 1'b0;
    endtask

    task automatic drive_m(input int i, input logic cyc, input logic stb, input logic we,
                           input logic [31:0] adr, input logic [2:0] cti);
        bus.m_cyc_i[i]          = cyc;
        bus.m_stb_i[i]          = stb;
        bus.m_we_i[i]           = we;
        bus.m_adr_i[i*32 +: 32] = adr;
        bus.m_dat_i[i*32 +: 32] = ~adr;
        bus.m_sel_i[i*4 +: 4]   = 4'hF;
        bus.m_cti_i[i*3 +: 3]   = cti;
    endtask

    task automatic do_reset();
        clear_bus();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_bus();
        drive_m(0, 1'b0, 1'b0, 1'b1, 32'h0000_00A0, CTI_CLASSIC);
        drive_m(1, 1'b0, 1'b0, 1'b0, 32'h0000_00B0, CTI_CLASSIC);
        tick();
        tick();
        @(negedge clk);
        checks++; if (bus.gnt_o !== 4'b0000) begin failures++; $display("FAIL reset_gnt got %b want 0000", bus.gnt_o); end
        checks++; if (bus.s_cyc_o !== 1'b0) begin failures++; $display("FAIL reset_s_cyc got %b want 0", bus.s_cyc_o); end
        checks++; if (bus.s_stb_o !== 1'b0) begin failures++; $display("FAIL reset_s_stb got %b want 0", bus.s_stb_o); end
        checks++; if (bus.m_ack_o !== 4'b0000) begin failures++; $display("FAIL reset_ack got %b want 0000", bus.m_ack_o); end
        checks++; if (bus.m_err_o !== 4'b0000) begin failures++; $display("FAIL reset_err got %b want 0000", bus.m_err_o); end
        checks++; if (bus.s_adr_o !== 32'h0000_00A0) begin failures++; $display("FAIL idle_mux_adr got %h want 000000a0", bus.s_adr_o); end
        checks++; if (bus.s_we_o !== 1'b1) begin failures++; $display("FAIL idle_mux_we got %b want 1", bus.s_we_o); end
        tick();
        rst_n       = 1'b1;
        bus.s_ack_i = 1'b1;
        bus.s_dat_i = 32'h1234_5678;
        @(negedge clk);
        checks++; if (bus.m_ack_o !== 4'b0000) begin failures++; $display("FAIL idle_ack_ignored got %b want 0000", bus.m_ack_o); end
        checks++; if (bus.m_dat_o !== 32'h1234_5678) begin failures++; $display("FAIL dat_broadcast got %h want 12345678", bus.m_dat_o); end
        tick();
        bus.s_ack_i = 1'b0;
    endtask

    task automatic test_single_read();
        do_reset();
        drive_m(2, 1'b1, 1'b1, 1'b0, 32'h4000_0010, CTI_CLASSIC);
        @(negedge clk);
        checks++; if (bus.gnt_o !== 4'b0000) begin failures++; $display("FAIL read_gnt_early got %b want 0000", bus.gnt_o); end
        tick();
        @(negedge clk);
        checks++; if (bus.gnt_o !== 4'b0100) begin failures++; $display("FAIL read_gnt got %b want 0100", bus.gnt_o); end
        checks++; if (bus.s_cyc_o !== 1'b1 || bus.s_stb_o !== 1'b1) begin failures++; $display("FAIL read_cyc_stb got %b%b want 11", bus.s_cyc_o, bus.s_stb_o); end
        checks++; if (bus.s_adr_o !== 32'h4000_0010) begin failures++; $display("FAIL read_adr got %h want 40000010", bus.s_adr_o); end
        checks++; if (bus.s_we_o !== 1'b0) begin failures++; $display("FAIL read_we got %b want 0", bus.s_we_o); end
        tick();
        bus.s_ack_i = 1'b1;
        bus.s_dat_i = 32'hCAFE_F00D;
        @(negedge clk);
        checks++; if (bus.m_ack_o !== 4'b0100) begin failures++; $display("FAIL read_ack got %b want 0100", bus.m_ack_o); end
        checks++; if (bus.m_dat_o !== 32'hCAFE_F00D) begin failures++; $display("FAIL read_data got %h want cafef00d", bus.m_dat_o); end
        tick();
        drive_m(2, 1'b0, 1'b0, 1'b0, 32'h4000_0010, CTI_CLASSIC);
        bus.s_ack_i = 1'b0;
        @(negedge clk);
        checks++; if (bus.m_ack_o !== 4'b0000) begin failures++; $display("FAIL read_ack_pulse got %b want 0000", bus.m_ack_o); end
        checks++; if (bus.gnt_o !== 4'b0100) begin failures++; $display("FAIL read_gnt_hold got %b want 0100", bus.gnt_o); end
        tick();
        @(negedge clk);
        checks++; if (bus.gnt_o !== 4'b0000 || bus.s_cyc_o !== 1'b0) begin failures++; $display("FAIL read_release got gnt=%b cyc=%b want 0000/0", bus.gnt_o, bus.s_cyc_o); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        drive_m(0, 1'b1, 1'b1, 1'b1, 32'h0000_0100, CTI_CLASSIC);
        drive_m(2, 1'b1, 1'b1, 1'b0, 32'h0000_0200, CTI_CLASSIC);
        tick();
        @(negedge clk);
        checks++; if (bus.gnt_o !== 4'b0001) begin failures++; $display("FAIL simul_first got %b want 0001", bus.gnt_o); end
        checks++; if (bus.s_adr_o !== 32'h0000_0100) begin failures++; $display("FAIL simul_adr0 got %h want 00000100", bus.s_adr_o); end
        tick();
        bus.s_ack_i = 1'b1;
        @(negedge clk);
        checks++; if (bus.m_ack_o !== 4'b0001) begin failures++; $display("FAIL simul_ack0 got %b want 0001", bus.m_ack_o); end
        tick();
        drive_m(0, 1'b0, 1'b0, 1'b0, 32'h0, CTI_CLASSIC);
        bus.s_ack_i = 1'b0;
        tick();
        @(negedge clk);
        checks++; if (bus.gnt_o !== 4'b0000 || bus.s_cyc_o !== 1'b0) begin failures++; $display("FAIL simul_dead got gnt=%b cyc=%b want 0000/0", bus.gnt_o, bus.s_cyc_o); end
        tick();
        @(negedge clk);
        checks++; if (bus.gnt_o !== 4'b0100) begin failures++; $display("FAIL simul_second got %b want 0100", bus.gnt_o); end
        checks++; if (bus.s_adr_o !== 32'h0000_0200) begin failures++; $display("FAIL simul_adr2 got %h want 00000200", bus.s_adr_o); end
        tick();
        drive_m(2, 1'b0, 1'b0, 1'b0, 32'h0, CTI_CLASSIC);
        tick();
    endtask

    task automatic test_rotation();
        int exp_order [5];
        exp_order = '{0, 1, 2, 3, 0};
        do_reset();
        for (int i = 0; i < 4; i++) drive_m(i, 1'b1, 1'b1, 1'b0, 32'h1000 + 32'(i * 16), CTI_CLASSIC);
        for (int k = 0; k < 5; k++) begin
            int n;
            int m;
            n = 0;
            m = exp_order[k];
            while (bus.gnt_o == 4'b0000 && n < 8) begin
                tick();
                n++;
            end
            checks++; if (bus.gnt_o !== 4'(1 << m)) begin failures++; $display("FAIL rot_grant[%0d] got %b want %b", k, bus.gnt_o, 4'(1 << m)); end
            bus.s_ack_i = 1'b1;
            @(negedge clk);
            checks++; if (bus.m_ack_o !== 4'(1 << m)) begin failures++; $display("FAIL rot_ack[%0d] got %b want %b", k, bus.m_ack_o, 4'(1 << m)); end
            tick();
            bus.m_cyc_i[m] = 1'b0;
            bus.m_stb_i[m] = 1'b0;
            bus.s_ack_i    = 1'b0;
            tick();
            checks++; if (bus.gnt_o !== 4'b0000) begin failures++; $display("FAIL rot_dead[%0d] got %b want 0000", k, bus.gnt_o); end
            bus.m_cyc_i[m] = 1'b1;
            bus.m_stb_i[m] = 1'b1;
        end
        clear_bus();
        tick();
        tick();
    endtask

    task automatic test_burst();
        logic [2:0] ctis [4];
        ctis = '{CTI_INC_BURST, CTI_INC_BURST, CTI_INC_BURST, CTI_END_BURST};
        do_reset();
        drive_m(1, 1'b1, 1'b1, 1'b0, 32'h0000_0300, CTI_INC_BURST);
        drive_m(3, 1'b1, 1'b1, 1'b1, 32'h0000_0700, CTI_CLASSIC);
        tick();
        @(negedge clk);
        checks++; if (bus.gnt_o !== 4'b0010) begin failures++; $display("FAIL burst_gnt got %b want 0010", bus.gnt_o); end
        for (int b = 0; b < 4; b++) begin
            tick();
            drive_m(1, 1'b1, 1'b1, 1'b0, 32'h0000_0300 + 32'(b * 4), ctis[b]);
            bus.s_ack_i = 1'b1;
            @(negedge clk);
            checks++; if (bus.m_ack_o !== 4'b0010) begin failures++; $display("FAIL burst_ack[%0d] got %b want 0010", b, bus.m_ack_o); end
            checks++; if (bus.s_cti_o !== ctis[b]) begin failures++; $display("FAIL burst_cti[%0d] got %b want %b", b, bus.s_cti_o, ctis[b]); end
            checks++; if (bus.s_adr_o !== 32'h0000_0300 + 32'(b * 4)) begin failures++; $display("FAIL burst_adr[%0d] got %h want %h", b, bus.s_adr_o, 32'h0000_0300 + 32'(b * 4)); end
            checks++; if (bus.gnt_o !== 4'b0010) begin failures++; $display("FAIL burst_hold[%0d] got %b want 0010", b, bus.gnt_o); end
        end
        tick();
        drive_m(1, 1'b0, 1'b0, 1'b0, 32'h0, CTI_CLASSIC);
        bus.s_ack_i = 1'b0;
        @(negedge clk);
        checks++; if (bus.gnt_o !== 4'b0010) begin failures++; $display("FAIL burst_drop_gnt got %b want 0010", bus.gnt_o); end
        tick();
        @(negedge clk);
        checks++; if (bus.gnt_o !== 4'b0000) begin failures++; $display("FAIL burst_dead got %b want 0000", bus.gnt_o); end
        tick();
        @(negedge clk);
        checks++; if (bus.gnt_o !== 4'b1000) begin failures++; $display("FAIL burst_next got %b want 1000", bus.gnt_o); end
        checks++; if (bus.s_adr_o !== 32'h0000_0700 || bus.s_we_o !== 1'b1) begin failures++; $display("FAIL burst_next_mux got adr=%h we=%b want 00000700/1", bus.s_adr_o, bus.s_we_o); end
        tick();
        clear_bus();
        tick();
        tick();
    endtask

    task automatic test_watchdog();
        do_reset();
        drive_m(1, 1'b1, 1'b1, 1'b0, 32'h0000_0500, CTI_CLASSIC);
        drive_m(3, 1'b1, 1'b1, 1'b0, 32'h0000_0600, CTI_CLASSIC);
        tick();
        @(negedge clk);
        checks++; if (bus.gnt_o !== 4'b0010 || bus.s_stb_o !== 1'b1) begin failures++; $display("FAIL wd_start got gnt=%b stb=%b want 0010/1", bus.gnt_o, bus.s_stb_o); end
`ifdef WBARB_TIMEOUT_EN
        for (int i = 1; i < 16; i++) begin
            tick();
            @(negedge clk);
            checks++; if (bus.m_err_o !== 4'b0000) begin failures++; $display("FAIL wd_early_err[%0d] got %b want 0000", i, bus.m_err_o); end
        end
        tick();
        @(negedge clk);
        checks++; if (bus.m_err_o !== 4'b0010) begin failures++; $display("FAIL wd_err got %b want 0010", bus.m_err_o); end
        checks++; if (bus.s_stb_o !== 1'b0) begin failures++; $display("FAIL wd_stb_forced got %b want 0", bus.s_stb_o); end
        tick();
        @(negedge clk);
        checks++; if (bus.m_err_o !== 4'b0000) begin failures++; $display("FAIL wd_err_pulse got %b want 0000", bus.m_err_o); end
        checks++; if (bus.s_stb_o !== 1'b1 || bus.gnt_o !== 4'b0010) begin failures++; $display("FAIL wd_still_owner got stb=%b gnt=%b want 1/0010", bus.s_stb_o, bus.gnt_o); end
`else
        for (int i = 1; i <= 20; i++) begin
            tick();
            @(negedge clk);
            checks++; if (bus.m_err_o !== 4'b0000) begin failures++; $display("FAIL nowd_err[%0d] got %b want 0000", i, bus.m_err_o); end
            if (i == 16) begin
                checks++; if (bus.s_stb_o !== 1'b1) begin failures++; $display("FAIL nowd_stb got %b want 1", bus.s_stb_o); end
            end
        end
`endif
        tick();
        drive_m(1, 1'b0, 1'b0, 1'b0, 32'h0, CTI_CLASSIC);
        tick();
        @(negedge clk);
        checks++; if (bus.gnt_o !== 4'b0000) begin failures++; $display("FAIL wd_dead got %b want 0000", bus.gnt_o); end
        tick();
        @(negedge clk);
        checks++; if (bus.gnt_o !== 4'b1000) begin failures++; $display("FAIL wd_next got %b want 1000", bus.gnt_o); end
        tick();
        clear_bus();
        tick();
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        drive_m(2, 1'b1, 1'b1, 1'b1, 32'h0000_0800, CTI_CLASSIC);
        tick();
        bus.s_ack_i = 1'b1;
        @(negedge clk);
        checks++; if (bus.gnt_o !== 4'b0100 || bus.s_cyc_o !== 1'b1) begin failures++; $display("FAIL rstmid_pre got gnt=%b cyc=%b want 0100/1", bus.gnt_o, bus.s_cyc_o); end
        checks++; if (bus.m_ack_o !== 4'b0100) begin failures++; $display("FAIL rstmid_pre_ack got %b want 0100", bus.m_ack_o); end
        #2;
        rst_n = 1'b0;
        drive_m(0, 1'b1, 1'b1, 1'b0, 32'h0000_0900, CTI_CLASSIC);
        #1;
        checks++; if (bus.gnt_o !== 4'b0000) begin failures++; $display("FAIL rstmid_gnt got %b want 0000", bus.gnt_o); end
        checks++; if (bus.s_cyc_o !== 1'b0 || bus.s_stb_o !== 1'b0) begin failures++; $display("FAIL rstmid_cyc_stb got %b%b want 00", bus.s_cyc_o, bus.s_stb_o); end
        checks++; if (bus.m_ack_o !== 4'b0000) begin failures++; $display("FAIL rstmid_ack_lost got %b want 0000", bus.m_ack_o); end
        tick();
        tick();
        rst_n       = 1'b1;
        bus.s_ack_i = 1'b0;
        tick();
        @(negedge clk);
        checks++; if (bus.gnt_o !== 4'b0001) begin failures++; $display("FAIL rstmid_next got %b want 0001", bus.gnt_o); end
        tick();
        clear_bus();
        tick();
        tick();
    endtask

    initial begin
        clear_bus();
        rst_n = 1'b0;
        test_reset();
        test_single_read();
        test_simultaneous();
        test_rotation();
        test_burst();
        test_watchdog();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout reached at %0t, bench did not complete", $time);
        $fatal(1, "bench time limit exceeded");
    end

endmodule
